// File: rtl/decoder_2_to_4_pipe.sv
// Registered binary-to-one-hot decoder behind a 2-entry valid/ready buffer.
// Build option: DECODER_2_TO_4_PIPE_HOLD_EN keeps the last lines while idle.
module decoder_2_to_4_pipe #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   out_lines,
  output logic [CNT_W-1:0]      dec_count
);
  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   head_q, head_d;
  logic [OUT_W-1:0]   skid_q, skid_d;
  logic [OUT_W-1:0]   dec;
  logic [OUT_W-1:0]   idle_lines;
  logic [CNT_W-1:0]   cnt_q;
  logic               rdy_q;
  logic               acc;
  logic               dlv;

  assign dec = in_en ? (OUT_W'(1) << in_sel) : '0;
  assign acc = in_valid & rdy_q;
  assign dlv = (state_q != EMPTY) & out_ready;

`ifdef DECODER_2_TO_4_PIPE_HOLD_EN
  assign idle_lines = head_q;
`else
  assign idle_lines = '0;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          head_d  = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && !dlv) begin
          skid_d  = dec;
          state_d = TWO;
        end else if (dlv && !acc) begin
          head_d  = idle_lines;
          state_d = EMPTY;
        end else if (acc && dlv) begin
          head_d  = dec;
        end
      end
      TWO: begin
        // skid entry becomes the new head
        if (dlv) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
        head_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != TWO);
      if (dlv && (head_q != '0))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_lines = head_q;
  assign dec_count = cnt_q;

endmodule

// File: tb/tb_decoder_2_to_4_pipe.sv
// Scoreboard bench for decoder_2_to_4_pipe.
// A second instance with CNT_W=2 exercises counter wrap-around.
module tb_decoder_2_to_4_pipe;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_lines;
  logic [7:0] dec_count;

  logic       in_ready_w;
  logic       out_valid_w;
  logic [3:0] out_lines_w;
  logic [1:0] dec_count_w;

  logic [3:0] exp_q[$];
  int         checks;
  int         errors;
  int         cnt8;
  int         cnt2;

  decoder_2_to_4_pipe #(.SEL_W(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lines (out_lines),
    .dec_count (dec_count)
  );

  decoder_2_to_4_pipe #(.SEL_W(2), .CNT_W(2)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .in_sel    (in_sel),
    .in_en     (in_en),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .out_lines (out_lines_w),
    .dec_count (dec_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one word; expected lines are pushed at the cycle it is accepted.
  task automatic send(input logic [1:0] sel, input logic en);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_en    = en;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(en ? (4'b0001 << sel) : 4'b0000);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  // Monitor: checks counters and pops expected lines on every delivery.
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt8 = 0;
      cnt2 = 0;
    end else begin
      check("dec_count", int'(dec_count), cnt8 % 256);
      check("dec_count_wrap", int'(dec_count_w), cnt2 % 4);
      check("twin_valid", int'(out_valid_w), int'(out_valid));
`ifndef DECODER_2_TO_4_PIPE_HOLD_EN
      if (!out_valid)
        check("idle_lines", int'(out_lines), 0);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %b expected none", out_lines);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("out_lines", int'(out_lines), int'(e));
          if (e != 4'b0000) begin
            cnt8 = cnt8 + 1;
            cnt2 = cnt2 + 1;
          end
        end
      end
    end
  end

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++)
      @(posedge clk);
    #1;
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cnt8      = 0;
    cnt2      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_en     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_lines", int'(out_lines), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_count", int'(dec_count), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with the sink always ready
    out_ready = 1'b1;
    send(2'd0, 1'b1);
    check("latency", int'(out_valid), 1);
    check("latency_lines", int'(out_lines), 4'b0001);
    send(2'd1, 1'b1);
    check("stream_ready", int'(in_ready), 1);
    send(2'd2, 1'b1);
    send(2'd3, 1'b1);
    check("stream_ready2", int'(in_ready), 1);
    drain();
    check("stream_count", int'(dec_count), 4);

    // Backpressure fills both entries
    out_ready = 1'b0;
    send(2'd2, 1'b1);
    send(2'd3, 1'b1);
    check("bp_ready", int'(in_ready), 0);
    check("bp_hold", int'(out_lines), 4'b0100);
    @(posedge clk);
    #1;
    check("bp_hold2", int'(out_lines), 4'b0100);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_back", int'(in_ready), 1);
    check("bp_second", int'(out_lines), 4'b1000);
    drain();

    // Disabled word is delivered but not counted
    send(2'd3, 1'b0);
    check("dis_valid", int'(out_valid), 1);
    check("dis_lines", int'(out_lines), 0);
    drain();
    check("dis_count", int'(dec_count), 6);

    // Wrap instance: 6 so far, push more to pass through 3 -> 0
    send(2'd1, 1'b1);
    send(2'd0, 1'b1);
    send(2'd2, 1'b1);
    drain();
    check("wrap_count", int'(dec_count_w), 1);

    // Reset in the middle of a full buffer
    out_ready = 1'b0;
    send(2'd1, 1'b1);
    send(2'd2, 1'b1);
    check("pre_rst_ready", int'(in_ready), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_lines", int'(out_lines), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_count", int'(dec_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_valid", int'(out_valid), 0);
    send(2'd3, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
